// File: rtl/updown_mod_counter.sv
// updown_mod_counter: loadable up/down modulo counter with 0..MAX range.
// Options:
//   - SATURATE selects whether the count wraps or holds at either end of the range.
//   - `UPDOWN_MOD_COUNTER_OVF_EN (optional, off by default) adds a sticky overflow
//     flag. The flag is set one cycle after a wrap/saturate pulse and is cleared
//     by clr_ovf.
// tc is combinational. q, wrap and ovf are registered. reset is async active-high.
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] ld_clip;
    logic [WIDTH-1:0] q_nxt;

    assign at_top = (q == TOP);
    assign at_bot = (q == '0);
    assign tc     = en & ((up & at_top) | (~up & at_bot));

    // next count: load beats enable, enable beats hold; the ends wrap or stick
    always_comb begin
        ld_clip = (load_val > TOP) ? TOP : load_val;
        q_nxt   = q;
        if (load) begin
            q_nxt = ld_clip;
        end else if (en) begin
            if (up)
                q_nxt = at_top ? ((SATURATE != 0) ? TOP : '0) : q + WIDTH'(1);
            else
                q_nxt = at_bot ? ((SATURATE != 0) ? '0 : TOP) : q - WIDTH'(1);
        end
    end

    // count register and one-cycle end-of-range pulse (suppressed by a load)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= tc & ~load;
        end
    end

`ifdef UPDOWN_MOD_COUNTER_OVF_EN
    // sticky flag follows the registered pulse; a fresh pulse beats a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else
            ovf <= wrap | (ovf & ~clr_ovf);
    end
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: four configurations run in lockstep from shared stimulus:
//   0: W4 M15 wrap, 1: W4 M15 saturate, 2: W4 M9 wrap, 3: W8 M255 wrap.
// A reference model computes each edge's outcome, which is queued and then
// compared after the edge.
module tb_updown_mod_counter;

`ifdef UPDOWN_MOD_COUNTER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, up = 1'b0, load = 1'b0, clr_ovf = 1'b0;
    logic [7:0] load_val = '0;
    logic [3:0] q0, q1, q2;
    logic [7:0] q3;
    logic [3:0] tcv, wrv, ovv;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .clr_ovf(clr_ovf), .q(q0), .tc(tcv[0]), .wrap(wrv[0]), .ovf(ovv[0]));
    updown_mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .clr_ovf(clr_ovf), .q(q1), .tc(tcv[1]), .wrap(wrv[1]), .ovf(ovv[1]));
    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .clr_ovf(clr_ovf), .q(q2), .tc(tcv[2]), .wrap(wrv[2]), .ovf(ovv[2]));
    updown_mod_counter #(.WIDTH(8), .MAX(255), .SATURATE(0)) u3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .q(q3), .tc(tcv[3]), .wrap(wrv[3]), .ovf(ovv[3]));

    typedef struct {
        int idx;
        int q;
        int w;
        int o;
    } exp_t;

    exp_t sb[$];
    int   mq[4], mw[4], mo[4];
    int   n_chk = 0, n_err = 0;

    function automatic int cmax(input int i);
        case (i)
            0, 1:    return 15;
            2:       return 9;
            default: return 255;
        endcase
    endfunction

    function automatic int csat(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int dq(input int i);
        case (i)
            0:       return int'(q0);
            1:       return int'(q1);
            2:       return int'(q2);
            default: return int'(q3);
        endcase
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d @%0t", tag, act, exp, $time);
        end
    endtask

    // one clock of stimulus: tc checked before the edge, registered state after
    task automatic step(input logic l, input logic [7:0] lv, input logic e,
                        input logic u, input logic c);
        exp_t x;
        @(negedge clk);
        load = l; load_val = lv; en = e; up = u; clr_ovf = c;
        #1;
        for (int i = 0; i < 4; i++) begin
            int lvi, t, nq, nw, no, mx;
            mx  = cmax(i);
            lvi = (i == 3) ? int'(lv) : int'(lv[3:0]);
            t   = (e && ((u && mq[i] == mx) || (!u && mq[i] == 0))) ? 1 : 0;
            chk($sformatf("tc%0d", i), int'(tcv[i]), t);
            if (l) begin
                nq = (lvi > mx) ? mx : lvi;
                nw = 0;
            end else if (e) begin
                if (u) nq = (mq[i] == mx) ? (csat(i) != 0 ? mx : 0) : mq[i] + 1;
                else   nq = (mq[i] == 0) ? (csat(i) != 0 ? 0 : mx) : mq[i] - 1;
                nw = t;
            end else begin
                nq = mq[i];
                nw = 0;
            end
            no = OVF_ON ? ((mw[i] != 0 || (mo[i] != 0 && !c)) ? 1 : 0) : 0;
            x.idx = i; x.q = nq; x.w = nw; x.o = no;
            sb.push_back(x);
            mq[i] = nq; mw[i] = nw; mo[i] = no;
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk($sformatf("q%0d", x.idx), dq(x.idx), x.q);
            chk($sformatf("wrap%0d", x.idx), int'(wrv[x.idx]), x.w);
            chk($sformatf("ovf%0d", x.idx), int'(ovv[x.idx]), x.o);
        end
    endtask

    // reset between edges with a load and count pending; all of it must be discarded
    task automatic apply_reset(input int edges);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_q%0d", i), dq(i), 0);
            chk($sformatf("rst_wrap%0d", i), int'(wrv[i]), 0);
            chk($sformatf("rst_ovf%0d", i), int'(ovv[i]), 0);
            mq[i] = 0; mw[i] = 0; mo[i] = 0;
        end
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'd5;
        repeat (edges) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("rsthold_q%0d", i), dq(i), 0);
        @(negedge clk);
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset(3);
        // count up through the top and back to 1
        repeat (17) step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        // count down from zero: wraps to MAX, saturating instance sticks at 0
        step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        // direction flip mid-run
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        // clipped load, then load overriding enable at the top
        step(1'b1, 8'd12, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
        // 8-bit full-range top: 254 -> 255 -> 0
        step(1'b1, 8'd254, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        // sticky flag: hold, clear, idle
        repeat (10) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        // clear arriving with a fresh pulse
        step(1'b1, 8'd15, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        // reset in the middle of a count at 7
        step(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
        apply_reset(3);
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        // random run
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0)
                apply_reset(1);
            else
                step(($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
